// File: rtl/filt_mac_pkg.sv
// Shared definitions for the filt_mac FIR filter: sequencer states and
// helpers that derive the number of MAC operations per output sample.
package filt_mac_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      MAC   = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } t_seq_state;

   // Half of n, rounded up: an odd-length symmetric filter keeps its centre tap unpaired
   function automatic int f_div2(input int n);
      return (n + 32'sd1) / 32'sd2;
   endfunction

   // MAC operations per output sample: folded pairs when symmetric, one per tap otherwise
   function automatic int f_n_ops(input int l, input int symm);
      return (symm != 32'sd0) ? f_div2(l) : l;
   endfunction

endpackage

// File: rtl/filt_mac_addr_gen.sv
// Combinational tap address generator for the circular delay line.
// Given the newest-sample pointer n and operation index k, it produces the
// newest-side address (n-k) mod L and, for symmetric filters, the
// oldest-side partner (n-(L-1-k)) mod L. The arithmetic is done on
// widened operands so lengths that are not a power of two wrap correctly.
module filt_mac_addr_gen
   import filt_mac_pkg::*;
#(
   parameter int gp_coeff_length = 17,
   parameter int gp_symm         = 1,
   parameter int AW              = 5,
   parameter int CW              = 4
) (
   input  logic [AW-1:0] n,
   input  logic [CW-1:0] k,
   output logic [AW-1:0] addr_a,
   output logic [AW-1:0] addr_b,
   output logic          pair_en
);

   localparam int            XW    = AW + 2;
   localparam logic [XW-1:0] L_X   = XW'(gp_coeff_length);
   localparam logic [XW-1:0] MID_X = XW'((gp_coeff_length - 1) / 2);
   localparam logic          L_ODD = ((gp_coeff_length % 2) == 1);

   logic [XW-1:0] n_x_s;
   logic [XW-1:0] k_x_s;

   assign n_x_s = XW'(n);
   assign k_x_s = XW'(k);

   // Reduce a value in [0, 2L) to [0, L)
   function automatic logic [AW-1:0] f_mod_l(input logic [XW-1:0] v);
      return (v >= L_X) ? AW'(v - L_X) : AW'(v);
   endfunction

   // Tap addresses and pre-adder pairing for the requested operation
   always_comb begin
      addr_a = f_mod_l(n_x_s + L_X - k_x_s);
      if (gp_symm != 0) begin
         // n-(L-1-k) mod L is the same as n+k+1 mod L
         addr_b  = f_mod_l(n_x_s + k_x_s + XW'(1));
         pair_en = !(L_ODD && (k_x_s == MID_X));
      end else begin
         addr_b  = f_mod_l(n_x_s + L_X - k_x_s);
         pair_en = 1'b0;
      end
   end

endmodule

// File: rtl/filt_mac_seq_ctrl.sv
// Sequencer for the time-shared MAC datapath of the filt_mac FIR filter.
// One accepted sample runs LOAD (write into delay RAM), N_OPS MAC cycles,
// gp_mac_lat FLUSH cycles to drain the MAC pipeline, then DONE (output
// load plus done pulse). Every control output is a register; only o_rdy
// is decoded combinationally from state and i_ena.
module filt_mac_seq_ctrl
   import filt_mac_pkg::*;
#(
   parameter  int gp_coeff_length = 17,
   parameter  int gp_symm         = 1,
   parameter  int gp_mac_lat      = 2,
   localparam int N_OPS           = f_n_ops(gp_coeff_length, gp_symm),
   localparam int AW              = $clog2(gp_coeff_length),
   localparam int CW              = (N_OPS > 1) ? $clog2(N_OPS) : 1
) (
   input  logic          i_clk,
   input  logic          i_rst_an,
   input  logic          i_ena,
   input  logic          i_vld,
   input  logic          i_ovf_clr,
   output logic          o_rdy,
   output logic          o_wr_en,
   output logic [AW-1:0] o_wr_addr,
   output logic [AW-1:0] o_rd_addr_a,
   output logic [AW-1:0] o_rd_addr_b,
   output logic          o_pair_en,
   output logic [CW-1:0] o_coeff_addr,
   output logic          o_acc_clr,
   output logic          o_acc_en,
   output logic          o_oup_load,
   output logic          o_done,
   output logic          o_busy,
   output logic          o_ovf
);

   localparam int            FW      = (gp_mac_lat > 1) ? $clog2(gp_mac_lat) : 1;
   localparam logic [FW-1:0] FL_LAST = FW'((gp_mac_lat > 0) ? (gp_mac_lat - 1) : 0);
   localparam logic [CW-1:0] K_LAST  = CW'(N_OPS - 1);
   localparam logic [AW-1:0] WP_LAST = AW'(gp_coeff_length - 1);

   t_seq_state    state_r;
   logic [AW-1:0] wp_r;
   logic [AW-1:0] n_r;
   logic [CW-1:0] k_r;
   logic [FW-1:0] fl_r;
   logic [CW-1:0] k_nxt_s;
   logic [AW-1:0] addr_a_s;
   logic [AW-1:0] addr_b_s;
   logic          pair_en_s;
   logic          rdy_s;

   assign rdy_s = i_ena && ((state_r == IDLE) || (state_r == DONE));
   assign o_rdy = rdy_s;

   // Index of the MAC operation that the next cycle will perform
   always_comb begin
      if (state_r == LOAD) begin
         k_nxt_s = {CW{1'b0}};
      end else begin
         k_nxt_s = k_r + CW'(1);
      end
   end

   filt_mac_addr_gen #(
      .gp_coeff_length (gp_coeff_length),
      .gp_symm         (gp_symm),
      .AW              (AW),
      .CW              (CW)
   ) u_addr_gen (
      .n       (n_r),
      .k       (k_nxt_s),
      .addr_a  (addr_a_s),
      .addr_b  (addr_b_s),
      .pair_en (pair_en_s)
   );

   // Sequencer FSM, pointers, overflow flag and registered control outputs
   always_ff @(posedge i_clk or negedge i_rst_an) begin
      if (!i_rst_an) begin
         state_r      <= IDLE;
         wp_r         <= {AW{1'b0}};
         n_r          <= {AW{1'b0}};
         k_r          <= {CW{1'b0}};
         fl_r         <= {FW{1'b0}};
         o_wr_en      <= 1'b0;
         o_wr_addr    <= {AW{1'b0}};
         o_rd_addr_a  <= {AW{1'b0}};
         o_rd_addr_b  <= {AW{1'b0}};
         o_pair_en    <= 1'b0;
         o_coeff_addr <= {CW{1'b0}};
         o_acc_clr    <= 1'b0;
         o_acc_en     <= 1'b0;
         o_oup_load   <= 1'b0;
         o_done       <= 1'b0;
         o_busy       <= 1'b0;
         o_ovf        <= 1'b0;
      end else begin
         // A sample that cannot be taken is dropped; set beats clear
         if (i_ena && i_vld && !rdy_s) begin
            o_ovf <= 1'b1;
         end else if (i_ovf_clr) begin
            o_ovf <= 1'b0;
         end else begin
            o_ovf <= o_ovf;
         end

         o_wr_en      <= 1'b0;
         o_wr_addr    <= {AW{1'b0}};
         o_rd_addr_a  <= {AW{1'b0}};
         o_rd_addr_b  <= {AW{1'b0}};
         o_pair_en    <= 1'b0;
         o_coeff_addr <= {CW{1'b0}};
         o_acc_clr    <= 1'b0;
         o_acc_en     <= 1'b0;
         o_oup_load   <= 1'b0;
         o_done       <= 1'b0;
         o_busy       <= 1'b0;

         if (!i_ena) begin
            // Abort: the write pointer survives so the delay line stays coherent
            state_r <= IDLE;
            k_r     <= {CW{1'b0}};
            fl_r    <= {FW{1'b0}};
         end else begin
            case (state_r)
               IDLE, DONE: begin
                  if (i_vld) begin
                     state_r   <= LOAD;
                     n_r       <= wp_r;
                     wp_r      <= (wp_r == WP_LAST) ? {AW{1'b0}} : (wp_r + AW'(1));
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= wp_r;
                     o_busy    <= 1'b1;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               LOAD: begin
                  state_r      <= MAC;
                  k_r          <= k_nxt_s;
                  o_rd_addr_a  <= addr_a_s;
                  o_rd_addr_b  <= addr_b_s;
                  o_pair_en    <= pair_en_s;
                  o_coeff_addr <= k_nxt_s;
                  o_acc_clr    <= 1'b1;
                  o_acc_en     <= 1'b1;
                  o_busy       <= 1'b1;
               end
               MAC: begin
                  if (k_r == K_LAST) begin
                     k_r <= {CW{1'b0}};
                     if (gp_mac_lat == 0) begin
                        state_r    <= DONE;
                        o_oup_load <= 1'b1;
                        o_done     <= 1'b1;
                     end else begin
                        state_r <= FLUSH;
                        fl_r    <= {FW{1'b0}};
                        o_busy  <= 1'b1;
                     end
                  end else begin
                     state_r      <= MAC;
                     k_r          <= k_nxt_s;
                     o_rd_addr_a  <= addr_a_s;
                     o_rd_addr_b  <= addr_b_s;
                     o_pair_en    <= pair_en_s;
                     o_coeff_addr <= k_nxt_s;
                     o_acc_en     <= 1'b1;
                     o_busy       <= 1'b1;
                  end
               end
               FLUSH: begin
                  if (fl_r == FL_LAST) begin
                     state_r    <= DONE;
                     fl_r       <= {FW{1'b0}};
                     o_oup_load <= 1'b1;
                     o_done     <= 1'b1;
                  end else begin
                     state_r <= FLUSH;
                     fl_r    <= fl_r + FW'(1);
                     o_busy  <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_filt_mac_seq_ctrl.sv
// Self-checking bench for filt_mac_seq_ctrl. A timeline model tracks how
// many cycles have passed since a sample was accepted and derives every
// expected output from that position with plain modular arithmetic.
module tb_filt_mac_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_an, ena, vld, ovf_clr;

   // symmetric, latency 2 instance
   logic       m_rdy, m_wr_en, m_pair, m_clr, m_acc, m_load, m_done, m_busy, m_ovf;
   logic [4:0] m_wr_addr, m_a, m_b;
   logic [3:0] m_coeff;
   // non-symmetric, latency 0 instance
   logic       x_rdy, x_wr_en, x_pair, x_clr, x_acc, x_load, x_done, x_busy, x_ovf;
   logic [4:0] x_wr_addr, x_a, x_b;
   logic [4:0] x_coeff;

   filt_mac_seq_ctrl #(.gp_coeff_length(17), .gp_symm(1), .gp_mac_lat(2)) dut (
      .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_vld(vld), .i_ovf_clr(ovf_clr),
      .o_rdy(m_rdy), .o_wr_en(m_wr_en), .o_wr_addr(m_wr_addr), .o_rd_addr_a(m_a),
      .o_rd_addr_b(m_b), .o_pair_en(m_pair), .o_coeff_addr(m_coeff), .o_acc_clr(m_clr),
      .o_acc_en(m_acc), .o_oup_load(m_load), .o_done(m_done), .o_busy(m_busy), .o_ovf(m_ovf));

   filt_mac_seq_ctrl #(.gp_coeff_length(17), .gp_symm(0), .gp_mac_lat(0)) dut_ns (
      .i_clk(clk), .i_rst_an(rst_an), .i_ena(ena), .i_vld(vld), .i_ovf_clr(ovf_clr),
      .o_rdy(x_rdy), .o_wr_en(x_wr_en), .o_wr_addr(x_wr_addr), .o_rd_addr_a(x_a),
      .o_rd_addr_b(x_b), .o_pair_en(x_pair), .o_coeff_addr(x_coeff), .o_acc_clr(x_clr),
      .o_acc_en(x_acc), .o_oup_load(x_load), .o_done(x_done), .o_busy(x_busy), .o_ovf(x_ovf));

   int checks = 0;
   int failures = 0;

   // model configuration and state
   int sel = 0;
   int L = 17, symm = 1, lat = 2, nops = 9, T = 13;
   int phase = 0;   // 0: no sample in flight, else cycle number since acceptance
   int n = 0;
   int wp = 0;
   logic ovf = 1'b0;

   function automatic logic [28:0] pack_dut();
      if (sel == 0)
         return {m_rdy, m_wr_en, m_wr_addr, m_a, m_b, m_pair, {1'b0, m_coeff},
                 m_clr, m_acc, m_load, m_done, m_busy, m_ovf};
      else
         return {x_rdy, x_wr_en, x_wr_addr, x_a, x_b, x_pair, x_coeff,
                 x_clr, x_acc, x_load, x_done, x_busy, x_ovf};
   endfunction

   function automatic logic [28:0] pack_exp();
      logic r, we, pr, cl, ae, ld, dn, bs;
      logic [4:0] wa5, a5, b5, c5;
      int k;
      r = ena && (phase == 0 || phase == T);
      we = 0; pr = 0; cl = 0; ae = 0; ld = 0; dn = 0; bs = 0;
      wa5 = 0; a5 = 0; b5 = 0; c5 = 0;
      if (phase == 1) begin
         we = 1; wa5 = 5'(n); bs = 1;
      end else if (phase >= 2 && phase <= nops + 1) begin
         k = phase - 2;
         ae = 1; bs = 1; cl = (k == 0); c5 = 5'(k);
         a5 = 5'(((n - k) % L + L) % L);
         if (symm != 0) begin
            b5 = 5'(((n - (L - 1 - k)) % L + L) % L);
            pr = !((L % 2 == 1) && (k == (L - 1) / 2));
         end else begin
            b5 = a5;
         end
      end else if (phase > nops + 1 && phase < T) begin
         bs = 1;
      end else if (phase == T) begin
         ld = 1; dn = 1;
      end
      return {r, we, wa5, a5, b5, pr, c5, cl, ae, ld, dn, bs, ovf};
   endfunction

   task automatic model_step();
      logic rdy_b;
      if (!rst_an) begin
         phase = 0; wp = 0; ovf = 0;
      end else begin
         rdy_b = ena && (phase == 0 || phase == T);
         if (ena && vld && !rdy_b) ovf = 1;
         else if (ovf_clr) ovf = 0;
         if (!ena) phase = 0;
         else if (rdy_b && vld) begin
            phase = 1; n = wp; wp = (wp + 1) % L;
         end
         else if (phase == T) phase = 0;
         else if (phase > 0) phase++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst_an = 0; ena = 0; vld = 0; ovf_clr = 0;
      phase = 0; wp = 0; ovf = 0;
      tick(); tick();
      rst_an = 1; ena = 1;
      tick();
   endtask

   task automatic test_reset();
      rst_an = 0; ena = 0; vld = 0; ovf_clr = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (pack_dut() !== 29'd0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", pack_dut());
         end
      end
      rst_an = 1; ena = 1;
      tick();
      checks++;
      if (m_rdy !== 1'b1 || m_ovf !== 1'b0) begin
         failures++;
         $display("FAIL reset_release rdy=%b ovf=%b exp rdy=1 ovf=0", m_rdy, m_ovf);
      end
   endtask

   task automatic test_single();
      int exp_a[9] = '{0, 16, 15, 14, 13, 12, 11, 10, 9};
      int done_cyc = -1, done_cnt = 0;
      vld = 1; tick(); vld = 0;
      for (int c = 1; c <= 14; c++) begin
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL single_cyc%0d got=%h exp=%h", c, pack_dut(), pack_exp());
         end
         if (c == 1) begin
            checks++;
            if (m_wr_en !== 1'b1 || m_wr_addr !== 5'd0) begin
               failures++;
               $display("FAIL single_write wr_en=%b addr=%0d exp 1/0", m_wr_en, m_wr_addr);
            end
         end
         if (c >= 2 && c <= 10) begin
            checks++;
            if (m_a !== 5'(exp_a[c-2]) || m_b !== 5'(c - 1)) begin
               failures++;
               $display("FAIL single_addr k=%0d a=%0d b=%0d exp a=%0d b=%0d",
                        c - 2, m_a, m_b, exp_a[c-2], c - 1);
            end
         end
         if (m_done === 1'b1) begin
            done_cnt++; done_cyc = c;
         end
         tick();
      end
      checks++;
      if (done_cnt != 1 || done_cyc != 13) begin
         failures++;
         $display("FAIL single_done count=%0d cycle=%0d exp 1/13", done_cnt, done_cyc);
      end
   endtask

   task automatic test_back_to_back();
      int addrs[$];
      int wcyc[$];
      int dones = 0;
      do_reset();
      vld = 1;
      for (int c = 1; c <= 18 * 13; c++) begin
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL b2b_cyc%0d got=%h exp=%h", c, pack_dut(), pack_exp());
         end
         if (m_wr_en === 1'b1) begin
            addrs.push_back(int'(m_wr_addr)); wcyc.push_back(c);
         end
         if (m_done === 1'b1) dones++;
      end
      vld = 0;
      checks++;
      if (addrs.size() != 18 || dones != 18) begin
         failures++;
         $display("FAIL b2b_count writes=%0d dones=%0d exp 18/18", addrs.size(), dones);
      end else begin
         for (int i = 0; i < 18; i++) begin
            checks++;
            if (addrs[i] != i % 17 || wcyc[i] != 1 + 13 * i) begin
               failures++;
               $display("FAIL b2b_sample%0d addr=%0d cyc=%0d exp %0d/%0d",
                        i + 1, addrs[i], wcyc[i], i % 17, 1 + 13 * i);
            end
         end
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_ovf();
      int wr = 0;
      int r;
      ovf_clr = 0;
      vld = 1; tick(); vld = 0;
      if (m_wr_en === 1'b1) wr++;
      r = $urandom_range(2, 8);
      for (int i = 0; i < r; i++) begin
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL ovf_pre got=%h exp=%h", pack_dut(), pack_exp());
         end
         if (m_wr_en === 1'b1) wr++;
      end
      vld = 1; tick(); vld = 0;
      checks++;
      if (m_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set got=%b exp=1", m_ovf);
      end
      for (int i = 0; i < 14; i++) begin
         if (m_wr_en === 1'b1) wr++;
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL ovf_post got=%h exp=%h", pack_dut(), pack_exp());
         end
      end
      checks++;
      if (wr != 1) begin
         failures++;
         $display("FAIL ovf_writes got=%0d exp=1", wr);
      end
      ovf_clr = 1; tick(); ovf_clr = 0;
      checks++;
      if (m_ovf !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clear got=%b exp=0", m_ovf);
      end
      vld = 1; tick(); vld = 0;
      checks++;
      if (m_wr_en !== 1'b1 || m_wr_addr !== 5'd2) begin
         failures++;
         $display("FAIL ovf_wp wr_en=%b addr=%0d exp 1/2", m_wr_en, m_wr_addr);
      end
      for (int i = 0; i < 3; i++) tick();
      vld = 1; ovf_clr = 1; tick(); vld = 0; ovf_clr = 0;
      checks++;
      if (m_ovf !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set_wins got=%b exp=1", m_ovf);
      end
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL ovf_tail got=%h exp=%h", pack_dut(), pack_exp());
         end
      end
   endtask

   task automatic test_abort();
      bit found = 0;
      int dones = 0;
      ovf_clr = 1; tick(); ovf_clr = 0;
      vld = 1; tick(); vld = 0;
      checks++;
      if (m_wr_addr !== 5'd3) begin
         failures++;
         $display("FAIL abort_first_addr got=%0d exp=3", m_wr_addr);
      end
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (m_acc === 1'b1 && m_coeff === 4'd4) found = 1;
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL abort_reach_k4 timeout exp coeff 4");
      end
      ena = 0; tick();
      checks++;
      if (m_acc !== 1'b0 || m_busy !== 1'b0 || m_rdy !== 1'b0) begin
         failures++;
         $display("FAIL abort_idle acc=%b busy=%b rdy=%b exp 0/0/0", m_acc, m_busy, m_rdy);
      end
      for (int i = 0; i < 20; i++) begin
         vld = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL abort_off got=%h exp=%h", pack_dut(), pack_exp());
         end
         if (m_done === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || m_ovf !== 1'b0) begin
         failures++;
         $display("FAIL abort_nodone dones=%0d ovf=%b exp 0/0", dones, m_ovf);
      end
      vld = 0; ena = 1; tick();
      vld = 1; tick(); vld = 0;
      checks++;
      if (m_wr_addr !== 5'd4) begin
         failures++;
         $display("FAIL abort_wp_kept got=%0d exp=4", m_wr_addr);
      end
      for (int i = 0; i < 20 && phase != nops + 2; i++) tick();
      rst_an = 0; #1;
      phase = 0; wp = 0; ovf = 0;
      checks++;
      if (pack_dut() !== pack_exp() || m_busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_reset got=%h exp=%h", pack_dut(), pack_exp());
      end
      tick(); tick();
      rst_an = 1; tick();
      vld = 1; tick(); vld = 0;
      checks++;
      if (m_wr_en !== 1'b1 || m_wr_addr !== 5'd0) begin
         failures++;
         $display("FAIL abort_reset_wp wr_en=%b addr=%0d exp 1/0", m_wr_en, m_wr_addr);
      end
      for (int i = 0; i < 14; i++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         ena = ($urandom_range(0, 7) != 0);
         vld = ($urandom_range(0, 2) == 0);
         ovf_clr = ($urandom_range(0, 4) == 0);
         tick();
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL random_cyc%0d got=%h exp=%h", i, pack_dut(), pack_exp());
         end
      end
      ena = 1; vld = 0; ovf_clr = 0;
   endtask

   task automatic test_nonsymm();
      int done_cyc = -1, macs = 0, pairs = 0;
      sel = 1; L = 17; symm = 0; lat = 0; nops = 17; T = 19;
      do_reset();
      vld = 1; tick(); vld = 0;
      for (int c = 1; c <= 20; c++) begin
         checks++;
         if (pack_dut() !== pack_exp()) begin
            failures++;
            $display("FAIL nonsymm_cyc%0d got=%h exp=%h", c, pack_dut(), pack_exp());
         end
         if (x_acc === 1'b1) begin
            macs++;
            checks++;
            if (x_b !== x_a) begin
               failures++;
               $display("FAIL nonsymm_addr_b got=%0d exp=%0d", x_b, x_a);
            end
         end
         if (x_pair === 1'b1) pairs++;
         if (x_done === 1'b1) done_cyc = c;
         tick();
      end
      checks++;
      if (macs != 17 || pairs != 0 || done_cyc != 19) begin
         failures++;
         $display("FAIL nonsymm_summary macs=%0d pairs=%0d done=%0d exp 17/0/19",
                  macs, pairs, done_cyc);
      end
   endtask

   initial begin
      rst_an = 0; ena = 0; vld = 0; ovf_clr = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_ovf();
      test_abort();
      test_random();
      test_nonsymm();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
